l2_line_transfer_engine: RTL

- Sits between the L2 cache and `main_memory_controller`.
- Turns one L2 miss into word-by-word main-memory transactions:
  - an optional writeback of the dirty victim line, then
  - a fill of the missing line.
- Returns the assembled fill line to L2 as a single-cycle pulse.
- Owns all sequencing of the memory controller's one-word request/ready protocol, so L2 deals only in whole lines.

---
 rtl/l2_line_transfer_engine_pkg.sv | 24 ++
 rtl/l2_line_transfer_engine_line_word_buffer.sv | 39 +++
 rtl/l2_line_transfer_engine.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/l2_line_transfer_engine_pkg.sv
// Shared configuration for the L2 line transfer engine: main-memory geometry
// and cache-line shape / transfer FSM encoding.
package main_memory_config;
  localparam int MAIN_MEMORY_ADDRESS_WIDTH = 8;
  localparam int MAIN_MEMORY_DATA_WIDTH    = 8;
endpackage

package cache_config;
  import main_memory_config::*;

  localparam int WORDS_PER_LINE = 4;

  typedef enum logic [2:0] {
    IDLE,
    WB_ISSUE,
    WB_WAIT,
    RD_ISSUE,
    RD_WAIT,
    RD_CAPTURE,
    DONE
  } xfer_state_t;

  typedef logic [WORDS_PER_LINE*MAIN_MEMORY_DATA_WIDTH-1:0] line_data_t;
endpackage

// File: rtl/l2_line_transfer_engine_line_word_buffer.sv
// Small register file holding one cache line as individually addressable words:
// whole-line load, single-word write and single-word read at an index.
module line_word_buffer #(
  parameter int WORDS = 4,
  parameter int IDX_W = 2,
  parameter int DW    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WORDS*DW-1:0]   load_line,
  input  logic                  write,
  input  logic [IDX_W-1:0]      write_idx,
  input  logic [DW-1:0]         write_word,
  input  logic [IDX_W-1:0]      read_idx,
  output logic [DW-1:0]         read_word,
  output logic [WORDS*DW-1:0]   line
);
  logic [DW-1:0] word_reg [WORDS];

  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
      // A whole-line load takes priority over a single-word write.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          word_reg[gi] <= '0;
        end else if (load) begin
          word_reg[gi] <= load_line[gi*DW +: DW];
        end else if (write && (write_idx == IDX_W'(gi))) begin
          word_reg[gi] <= write_word;
        end
      end

      assign line[gi*DW +: DW] = word_reg[gi];
    end
  endgenerate

  assign read_word = word_reg[read_idx];
endmodule

// File: rtl/l2_line_transfer_engine.sv
// Converts one L2 miss into an optional word-by-word victim writeback followed
// by a word-by-word fill, returning the assembled line as a one-cycle pulse.
module l2_line_transfer_engine #(
  parameter int WORDS_PER_LINE = cache_config::WORDS_PER_LINE,
  parameter int WORD_IDX_W     = $clog2(WORDS_PER_LINE),
  parameter int LINE_ADDR_W    = main_memory_config::MAIN_MEMORY_ADDRESS_WIDTH - WORD_IDX_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       miss_valid,
  output logic                       miss_ready,
  input  logic [LINE_ADDR_W-1:0]     miss_line_addr,
  input  logic                       victim_dirty,
  input  logic [LINE_ADDR_W-1:0]     victim_line_addr,
  input  logic [WORDS_PER_LINE*main_memory_config::MAIN_MEMORY_DATA_WIDTH-1:0] victim_line_data,
  output logic                       fill_valid,
  output logic [LINE_ADDR_W-1:0]     fill_line_addr,
  output logic [WORDS_PER_LINE*main_memory_config::MAIN_MEMORY_DATA_WIDTH-1:0] fill_line_data,
  output logic                       busy,
  output logic                       mem_read_request,
  output logic                       mem_write_request,
  output logic [main_memory_config::MAIN_MEMORY_ADDRESS_WIDTH-1:0] mem_address,
  output logic [main_memory_config::MAIN_MEMORY_DATA_WIDTH-1:0]    mem_write_data,
  input  logic [main_memory_config::MAIN_MEMORY_DATA_WIDTH-1:0]    mem_read_data,
  input  logic                       mem_ready
);
  import main_memory_config::*;
  import cache_config::*;

  localparam int DW = MAIN_MEMORY_DATA_WIDTH;
  localparam int LW = WORDS_PER_LINE * DW;
  localparam logic [WORD_IDX_W-1:0] LAST_IDX = WORD_IDX_W'(WORDS_PER_LINE - 1);

  xfer_state_t             state_reg, state_next;
  logic [WORD_IDX_W-1:0]   word_idx_reg, word_idx_next;
  logic [LINE_ADDR_W-1:0]  miss_addr_reg, victim_addr_reg, fill_addr_reg;
  logic [LW-1:0]           fill_data_reg;
  logic                    accept, capture, last_word, wb_phase;
  logic [LW-1:0]           fill_buf_line, victim_line_unused;
  logic [DW-1:0]           fill_word_unused;

  assign last_word = (word_idx_reg == LAST_IDX);
  assign wb_phase  = (state_reg == WB_ISSUE) || (state_reg == WB_WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      word_idx_reg    <= '0;
      miss_addr_reg   <= '0;
      victim_addr_reg <= '0;
      fill_addr_reg   <= '0;
      fill_data_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      word_idx_reg <= word_idx_next;
      if (accept) begin
        miss_addr_reg   <= miss_line_addr;
        victim_addr_reg <= victim_line_addr;
      end
      // The last word arrives straight from memory; earlier words are already buffered.
      if (capture && last_word) begin
        fill_addr_reg <= miss_addr_reg;
        fill_data_reg <= {mem_read_data, fill_buf_line[LW-DW-1:0]};
      end
    end
  end

  always_comb begin
    state_next        = state_reg;
    word_idx_next     = word_idx_reg;
    accept            = 1'b0;
    capture           = 1'b0;
    miss_ready        = 1'b0;
    fill_valid        = 1'b0;
    mem_read_request  = 1'b0;
    mem_write_request = 1'b0;
    case (state_reg)
      IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) begin
          accept        = 1'b1;
          word_idx_next = '0;
          state_next    = victim_dirty ? WB_ISSUE : RD_ISSUE;
        end
      end
      WB_ISSUE: begin
        mem_write_request = 1'b1;
        state_next        = WB_WAIT;
      end
      WB_WAIT: begin
        if (mem_ready) begin
          if (last_word) begin
            word_idx_next = '0;
            state_next    = RD_ISSUE;
          end else begin
            word_idx_next = word_idx_reg + 1'b1;
            state_next    = WB_ISSUE;
          end
        end
      end
      RD_ISSUE: begin
        mem_read_request = 1'b1;
        state_next       = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_ready) state_next = RD_CAPTURE;
      end
      RD_CAPTURE: begin
        // Controller read data is registered, so it is valid only in this cycle.
        capture = 1'b1;
        if (last_word) begin
          state_next = DONE;
        end else begin
          word_idx_next = word_idx_reg + 1'b1;
          state_next    = RD_ISSUE;
        end
      end
      DONE: begin
        fill_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  line_word_buffer #(
    .WORDS (WORDS_PER_LINE),
    .IDX_W (WORD_IDX_W),
    .DW    (DW)
  ) victim_buf (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .load_line  (victim_line_data),
    .write      (1'b0),
    .write_idx  ('0),
    .write_word ('0),
    .read_idx   (word_idx_reg),
    .read_word  (mem_write_data),
    .line       (victim_line_unused)
  );

  line_word_buffer #(
    .WORDS (WORDS_PER_LINE),
    .IDX_W (WORD_IDX_W),
    .DW    (DW)
  ) fill_buf (
    .clk        (clk),
    .reset      (reset),
    .load       (1'b0),
    .load_line  ('0),
    .write      (capture),
    .write_idx  (word_idx_reg),
    .write_word (mem_read_data),
    .read_idx   (word_idx_reg),
    .read_word  (fill_word_unused),
    .line       (fill_buf_line)
  );

  assign mem_address    = {wb_phase ? victim_addr_reg : miss_addr_reg, word_idx_reg};
  assign busy           = !miss_ready;
  assign fill_line_addr = fill_addr_reg;
  assign fill_line_data = fill_data_reg;
endmodule
